// File: rtl/key_debouncer_pkg.sv
// key_debouncer_pkg: shared FSM state type and polarity helper for the key debouncer
package key_debouncer_pkg;
  typedef enum logic [1:0] {RELEASED, PEND_PRESS, PRESSED, PEND_RELEASE} state_e;
  function automatic logic released_level(input bit active_low);
    return active_low;
  endfunction
endpackage

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: one key's synchronizer, counter-qualified debounce FSM and strobes
module key_debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic pressed_o,
  output logic press_o,
  output logic release_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic REL = released_level(ACTIVE_LOW);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);
  logic sync1_q, sync2_q;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pressed_q, pressed_d, press_q, press_d, release_q, release_d;
  logic at_rel, done;
  assign at_rel = sync2_q == REL;
  assign done = cnt_q == LIMIT;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= REL;
      sync2_q <= REL;
      state_q <= RELEASED;
      cnt_q <= '0;
      pressed_q <= 1'b0;
      press_q <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      pressed_q <= pressed_d;
      press_q <= press_d;
      release_q <= release_d;
    end
  end
  // A return to the stable level during PEND drops all accumulated credit
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      RELEASED: if (!at_rel) begin
        state_d = PEND_PRESS;
        cnt_d = ONE;
      end
      PEND_PRESS: if (at_rel) begin
        state_d = RELEASED;
        cnt_d = '0;
      end else if (done) begin
        state_d = PRESSED;
        cnt_d = '0;
      end else cnt_d = cnt_q + ONE;
      PRESSED: if (at_rel) begin
        state_d = PEND_RELEASE;
        cnt_d = ONE;
      end
      PEND_RELEASE: if (!at_rel) begin
        state_d = PRESSED;
        cnt_d = '0;
      end else if (done) begin
        state_d = RELEASED;
        cnt_d = '0;
      end else cnt_d = cnt_q + ONE;
      default: begin
        state_d = RELEASED;
        cnt_d = '0;
      end
    endcase
  end
  always_comb begin
    press_d = state_q == PEND_PRESS && !at_rel && done;
    release_d = state_q == PEND_RELEASE && at_rel && done;
    pressed_d = press_d ? 1'b1 : release_d ? 1'b0 : pressed_q;
  end
  assign level_o = pressed_q ^ ACTIVE_LOW;
  assign pressed_o = pressed_q;
  assign press_o = press_q;
  assign release_o = release_q;
endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: WIDTH independent debounced key channels with press/release strobes
module key_debouncer #(
  parameter int WIDTH = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_pin,
  output logic [WIDTH-1:0] key_level,
  output logic [WIDTH-1:0] key_pressed,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .pin_i(key_pin[i]),
      .level_o(key_level[i]),
      .pressed_o(key_pressed[i]),
      .press_o(press_pulse[i]),
      .release_o(release_pulse[i])
    );
  end
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: scoreboard bench for two debouncer configurations against a pin-history model
module tb_key_debouncer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pin_a = 1'b1;
  logic [3:0] pin_b = 4'b0000;
  logic lvl_a, prs_a, pp_a, rp_a;
  logic [3:0] lvl_b, prs_b, pp_b, rp_b;
  int checks = 0, passes = 0, tick = 0;
  typedef struct {int cyc; int cfg; logic [3:0] pr; logic [3:0] rl;} ev_t;
  ev_t q[$];
  ev_t ev;
  logic [3:0] h1[2], h2[2], acc[2], ep[2], er[2];
  int run[2][4];

  key_debouncer #(.WIDTH(1), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .reset(reset), .key_pin(pin_a), .key_level(lvl_a),
    .key_pressed(prs_a), .press_pulse(pp_a), .release_pulse(rp_a)
  );
  key_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .reset(reset), .key_pin(pin_b), .key_level(lvl_b),
    .key_pressed(prs_b), .press_pulse(pp_b), .release_pulse(rp_b)
  );

  always #5 clk = ~clk;

  function automatic int dc(input int c);
    return c == 0 ? 4 : 1;
  endfunction
  function automatic logic al(input int c);
    return c == 0 ? 1'b1 : 1'b0;
  endfunction
  function automatic int wd(input int c);
    return c == 0 ? 1 : 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at tick %0d: got %0h expected %0h", name, tick, act, exp);
  endtask

  // Reference: a change is accepted once the twice-delayed pin disagrees with the
  // accepted level on DEBOUNCE_CYCLES+1 consecutive clock edges
  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      h1[c] = {4{al(c)}};
      h2[c] = {4{al(c)}};
      acc[c] = 4'b0000;
      for (int k = 0; k < 4; k++) run[c][k] = 0;
    end
    q.delete();
  endtask

  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      logic [3:0] pv, pr, rl;
      logic seen;
      pv = (c == 0) ? {3'b000, pin_a} : pin_b;
      pr = 4'b0000;
      rl = 4'b0000;
      for (int k = 0; k < wd(c); k++) begin
        seen = h2[c][k];
        h2[c][k] = h1[c][k];
        h1[c][k] = pv[k];
        if ((seen != al(c)) != acc[c][k]) run[c][k]++;
        else run[c][k] = 0;
        if (run[c][k] == dc(c) + 1) begin
          acc[c][k] = ~acc[c][k];
          run[c][k] = 0;
          if (acc[c][k]) pr[k] = 1'b1;
          else rl[k] = 1'b1;
        end
      end
      if ((pr | rl) != 4'b0000) q.push_back('{tick + 1, c, pr, rl});
    end
  endtask

  initial model_reset();
  always @(posedge clk) tick <= tick + 1;
  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    ep[0] = 4'b0000; ep[1] = 4'b0000;
    er[0] = 4'b0000; er[1] = 4'b0000;
    while (q.size() > 0 && q[0].cyc <= tick) begin
      ev = q.pop_front();
      if (ev.cyc == tick) begin
        ep[ev.cfg] = ev.pr;
        er[ev.cfg] = ev.rl;
      end
    end
    chk("press_a", {31'b0, pp_a}, {28'b0, ep[0]});
    chk("release_a", {31'b0, rp_a}, {28'b0, er[0]});
    chk("pressed_a", {31'b0, prs_a}, {31'b0, acc[0][0]});
    chk("level_a", {31'b0, lvl_a}, {31'b0, ~acc[0][0]});
    chk("press_b", {28'b0, pp_b}, {28'b0, ep[1]});
    chk("release_b", {28'b0, rp_b}, {28'b0, er[1]});
    chk("pressed_b", {28'b0, prs_b}, {28'b0, acc[1]});
    chk("level_b", {28'b0, lvl_b}, {28'b0, acc[1]});
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_level_a"}, {31'b0, lvl_a}, 32'd1);
    chk({tag, "_pressed_a"}, {31'b0, prs_a}, 32'd0);
    chk({tag, "_pulses_a"}, {30'b0, pp_a, rp_a}, 32'd0);
    chk({tag, "_level_b"}, {28'b0, lvl_b}, 32'd0);
    chk({tag, "_pressed_b"}, {28'b0, prs_b}, 32'd0);
    chk({tag, "_pulses_b"}, {24'b0, pp_b, rp_b}, 32'd0);
  endtask

  initial begin
    cycles(2);
    reset_check("reset_init");
    reset = 1'b0;
    cycles(4);
    pin_a = 1'b0; cycles(12);
    #($urandom_range(1, 4));
    reset = 1'b1; pin_a = 1'b1;
    #1 reset_check("reset_async");
    @(negedge clk); reset = 1'b0; cycles(4);
    pin_a = 1'b0; cycles(3); pin_a = 1'b1; cycles(2); pin_a = 1'b0; cycles(12);
    pin_a = 1'b1; cycles(3); pin_a = 1'b0; cycles(1); pin_a = 1'b1; cycles(12);
    pin_a = 1'b0; cycles(4);
    #2 reset = 1'b1;
    #1 reset_check("reset_pend");
    @(negedge clk); reset = 1'b0; cycles(12);
    pin_a = 1'b1; cycles(10);
    pin_b = 4'b1010; cycles(5);
    pin_b = 4'b0010; cycles(1); pin_b = 4'b1010; cycles(5);
    pin_b = 4'b0000; cycles(5);
    pin_b = 4'b0010; cycles(1); pin_b = 4'b1010; cycles(5);
    pin_b = 4'b1000; cycles(1); pin_b = 4'b0000; cycles(5);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) pin_a = ~pin_a;
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 3) == 0) pin_b[k] = ~pin_b[k];
      if ($urandom_range(0, 499) == 0) begin
        #3 reset = 1'b1;
        @(negedge clk); reset = 1'b0;
      end
    end
    cycles(12);
    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
